// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU control encodings and
// the E-stage control bundle carried by the ID/EX register.
package mips_pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUCTRL_W  = 3;

  typedef enum logic [ALUCTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      memto_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_control;
  } ctrl_e_t;

endpackage

// File: rtl/decode_execute_register_if.sv
// D-side inputs, hazard controls and E-side outputs of the ID/EX register.
// slave = the register itself, master = the decode/hazard side driving it.
interface decode_execute_register_if #(
  parameter int COUNT_W = 16
);
  // hazard unit controls
  logic FlushE;
  logic StallE;
  // decode stage
  logic ValidD;
  logic RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [mips_pipe_pkg::ALUCTRL_W-1:0]  ALUControlD;
  logic [mips_pipe_pkg::DATA_W-1:0]     RD1D, RD2D, SignImmD;
  logic [mips_pipe_pkg::REG_ADDR_W-1:0] RsD, RtD, RdD;
  // execute stage
  logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [mips_pipe_pkg::ALUCTRL_W-1:0]  ALUControlE;
  logic [mips_pipe_pkg::DATA_W-1:0]     RD1E, RD2E, SignImmE;
  logic [mips_pipe_pkg::REG_ADDR_W-1:0] RsE, RtE, RdE, WriteRegE;
  logic                                 ValidE;
  logic [COUNT_W-1:0]                   BubbleCount;

  modport master (
    output FlushE, StallE, ValidD,
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
    output ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
    input  ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
    input  ValidE, BubbleCount
  );

  modport slave (
    input  FlushE, StallE, ValidD,
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
    input  ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
    output ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
    output ValidE, BubbleCount
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + COUNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register: captures decode-stage state each cycle, inserts
// all-zero bubbles on FlushE, holds on StallE and counts inserted bubbles.
module decode_execute_register
  import mips_pipe_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  decode_execute_register_if.slave    bus
);

  ctrl_e_t                 ctrl_d;
  ctrl_e_t                 ctrl_reg;
  logic [DATA_W-1:0]       rd1_reg, rd2_reg, imm_reg;
  logic [REG_ADDR_W-1:0]   rs_reg, rt_reg, rd_reg;
  logic                    valid_reg;

  assign ctrl_d = '{
    reg_write:   bus.RegWriteD,
    memto_reg:   bus.MemtoRegD,
    mem_write:   bus.MemWriteD,
    alu_src:     bus.ALUSrcD,
    reg_dst:     bus.RegDstD,
    alu_control: alu_ctrl_e'(bus.ALUControlD)
  };

  // Reset and flush both clear every field, so register numbers read as $0 and
  // the hazard unit can never match against a bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      ctrl_reg  <= '0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (!bus.StallE) begin
      ctrl_reg  <= ctrl_d;
      rd1_reg   <= bus.RD1D;
      rd2_reg   <= bus.RD2D;
      imm_reg   <= bus.SignImmD;
      rs_reg    <= bus.RsD;
      rt_reg    <= bus.RtD;
      rd_reg    <= bus.RdD;
      valid_reg <= bus.ValidD;
    end
  end

  // Counter gives reset priority over the increment internally.
  sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_bubble_count (
    .clk   (clk),
    .srst  (reset),
    .inc   (bus.FlushE),
    .count (bus.BubbleCount)
  );

  assign bus.RegWriteE   = ctrl_reg.reg_write;
  assign bus.MemtoRegE   = ctrl_reg.memto_reg;
  assign bus.MemWriteE   = ctrl_reg.mem_write;
  assign bus.ALUSrcE     = ctrl_reg.alu_src;
  assign bus.RegDstE     = ctrl_reg.reg_dst;
  assign bus.ALUControlE = ctrl_reg.alu_control;
  assign bus.RD1E        = rd1_reg;
  assign bus.RD2E        = rd2_reg;
  assign bus.SignImmE    = imm_reg;
  assign bus.RsE         = rs_reg;
  assign bus.RtE         = rt_reg;
  assign bus.RdE         = rd_reg;
  assign bus.ValidE      = valid_reg;
  assign bus.WriteRegE   = ctrl_reg.reg_dst ? rd_reg : rt_reg;

endmodule

// File: tb/tb_decode_execute_register.sv
// Self-checking bench for decode_execute_register: directed scenarios followed by
// random reset/flush/stall traffic, checked against a behavioural pipeline model.
module tb_decode_execute_register;

  typedef struct packed {
    logic        rw, m2r, mw, asrc, rdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } fields_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_execute_register_if #(.COUNT_W(16)) bus  ();
  decode_execute_register_if #(.COUNT_W(4))  bus4 ();

  decode_execute_register #(.COUNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  decode_execute_register #(.COUNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  assign bus4.FlushE      = bus.FlushE;
  assign bus4.StallE      = bus.StallE;
  assign bus4.ValidD      = bus.ValidD;
  assign bus4.RegWriteD   = bus.RegWriteD;
  assign bus4.MemtoRegD   = bus.MemtoRegD;
  assign bus4.MemWriteD   = bus.MemWriteD;
  assign bus4.ALUSrcD     = bus.ALUSrcD;
  assign bus4.RegDstD     = bus.RegDstD;
  assign bus4.ALUControlD = bus.ALUControlD;
  assign bus4.RD1D        = bus.RD1D;
  assign bus4.RD2D        = bus.RD2D;
  assign bus4.SignImmD    = bus.SignImmD;
  assign bus4.RsD         = bus.RsD;
  assign bus4.RtD         = bus.RtD;
  assign bus4.RdD         = bus.RdD;

  fields_t din, exp_e;
  logic    flush, stall;
  int      exp_cnt, exp_cnt4;
  int      checks = 0;
  int      errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    bus.FlushE      = flush;
    bus.StallE      = stall;
    bus.ValidD      = din.valid;
    bus.RegWriteD   = din.rw;
    bus.MemtoRegD   = din.m2r;
    bus.MemWriteD   = din.mw;
    bus.ALUSrcD     = din.asrc;
    bus.RegDstD     = din.rdst;
    bus.ALUControlD = din.alu;
    bus.RD1D        = din.rd1;
    bus.RD2D        = din.rd2;
    bus.SignImmD    = din.imm;
    bus.RsD         = din.rs;
    bus.RtD         = din.rt;
    bus.RdD         = din.rd;
  endtask

  task automatic compare_all();
    logic [4:0] wr;
    wr = exp_e.rdst ? exp_e.rd : exp_e.rt;
    check_val("RegWriteE",   32'(bus.RegWriteE),   32'(exp_e.rw));
    check_val("MemtoRegE",   32'(bus.MemtoRegE),   32'(exp_e.m2r));
    check_val("MemWriteE",   32'(bus.MemWriteE),   32'(exp_e.mw));
    check_val("ALUSrcE",     32'(bus.ALUSrcE),     32'(exp_e.asrc));
    check_val("RegDstE",     32'(bus.RegDstE),     32'(exp_e.rdst));
    check_val("ALUControlE", 32'(bus.ALUControlE), 32'(exp_e.alu));
    check_val("RD1E",        bus.RD1E,             exp_e.rd1);
    check_val("RD2E",        bus.RD2E,             exp_e.rd2);
    check_val("SignImmE",    bus.SignImmE,         exp_e.imm);
    check_val("RsE",         32'(bus.RsE),         32'(exp_e.rs));
    check_val("RtE",         32'(bus.RtE),         32'(exp_e.rt));
    check_val("RdE",         32'(bus.RdE),         32'(exp_e.rd));
    check_val("WriteRegE",   32'(bus.WriteRegE),   32'(wr));
    check_val("ValidE",      32'(bus.ValidE),      32'(exp_e.valid));
    check_val("BubbleCount", 32'(bus.BubbleCount), 32'(exp_cnt));
    check_val("BubbleCount4", 32'(bus4.BubbleCount), 32'(exp_cnt4));
  endtask

  // One clock: apply inputs, advance the reference model at the edge, then compare.
  task automatic cycle();
    drive();
    @(posedge clk);
    if (reset) begin
      exp_e    = '0;
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end else if (flush) begin
      exp_e    = '0;
      exp_cnt  = (exp_cnt  < 65535) ? exp_cnt  + 1 : exp_cnt;
      exp_cnt4 = (exp_cnt4 < 15)    ? exp_cnt4 + 1 : exp_cnt4;
    end else if (!stall) begin
      exp_e = din;
    end
    #1;
    compare_all();
    $display("cyc rst=%0b flush=%0b stall=%0b validE=%0b wr=%0d cnt=%0d cnt4=%0d",
             reset, flush, stall, bus.ValidE, bus.WriteRegE, bus.BubbleCount, bus4.BubbleCount);
  endtask

  task automatic rand_din();
    din.rw    = 1'($urandom);
    din.m2r   = 1'($urandom);
    din.mw    = 1'($urandom);
    din.asrc  = 1'($urandom);
    din.rdst  = 1'($urandom);
    din.alu   = 3'($urandom);
    din.rd1   = $urandom;
    din.rd2   = $urandom;
    din.imm   = $urandom;
    din.rs    = 5'($urandom);
    din.rt    = 5'($urandom);
    din.rd    = 5'($urandom);
    din.valid = 1'($urandom);
  endtask

  initial begin
    exp_e = '0; exp_cnt = 0; exp_cnt4 = 0;
    flush = 1'b0; stall = 1'b0;

    // 1: reset with all D inputs high
    reset = 1'b1; din = '1; flush = 1'b1; stall = 1'b1;
    cycle();
    check_val("t1_WriteRegE", 32'(bus.WriteRegE), 32'd0);
    check_val("t1_Count", 32'(bus.BubbleCount), 32'd0);
    reset = 1'b0; flush = 1'b0; stall = 1'b0;

    // 2: load and WriteRegE muxing
    din = '0; din.rs = 5'd3; din.rt = 5'd4; din.rd = 5'd7; din.rdst = 1'b1;
    din.rd1 = 32'hDEADBEEF; din.valid = 1'b1;
    cycle();
    check_val("t2_RsE", 32'(bus.RsE), 32'd3);
    check_val("t2_RtE", 32'(bus.RtE), 32'd4);
    check_val("t2_WriteRegE_rd", 32'(bus.WriteRegE), 32'd7);
    check_val("t2_RD1E", bus.RD1E, 32'hDEADBEEF);
    check_val("t2_ValidE", 32'(bus.ValidE), 32'd1);
    din.rdst = 1'b0;
    cycle();
    check_val("t2_WriteRegE_rt", 32'(bus.WriteRegE), 32'd4);

    // 3: lw then a single flush
    din = '0; din.m2r = 1'b1; din.rw = 1'b1; din.rt = 5'd5; din.valid = 1'b1;
    cycle();
    check_val("t3_MemtoRegE", 32'(bus.MemtoRegE), 32'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_val("t3_MemtoRegE_flushed", 32'(bus.MemtoRegE), 32'd0);
    check_val("t3_WriteRegE", 32'(bus.WriteRegE), 32'd0);
    check_val("t3_Count", 32'(bus.BubbleCount), 32'd1);

    // 4: stall holds for 3 cycles, then stall+flush inserts a bubble
    din = '0; din.rs = 5'd9; din.rd1 = 32'h12345678; din.valid = 1'b1;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_din();
      cycle();
      check_val("t4_RsE_held", 32'(bus.RsE), 32'd9);
      check_val("t4_RD1E_held", bus.RD1E, 32'h12345678);
    end
    flush = 1'b1;
    cycle();
    check_val("t4_Count", 32'(bus.BubbleCount), 32'd2);
    check_val("t4_ValidE", 32'(bus.ValidE), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // 5: long flush burst saturates the narrow counter
    flush = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    check_val("t5_Count4_sat", 32'(bus4.BubbleCount), 32'hF);
    check_val("t5_Count16", 32'(bus.BubbleCount), 32'd22);

    // 6: reset in the middle of a flush burst
    reset = 1'b1;
    cycle();
    check_val("t6_Count", 32'(bus.BubbleCount), 32'd0);
    check_val("t6_Count4", 32'(bus4.BubbleCount), 32'd0);
    reset = 1'b0; flush = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_din();
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 15);
      stall = ($urandom_range(0, 99) < 20);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
